// File: rtl/vc_plane_pkg.sv
// ---------------------------------------------------------------------------
// vc_plane_pkg : shared constants and helpers for the VC-plane link blocks
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vc_plane_pkg;

  localparam int VC_DEFAULT         = 4;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Plane-index buses carry one spare bit so out-of-range indices are encodable.
  function automatic int plane_idx_width(input int vc);
    return vc + 1;
  endfunction

  localparam int PLANE_IDX_W_DEFAULT = plane_idx_width(VC_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/vc_plane_fifo.sv
// ---------------------------------------------------------------------------
// vc_plane_fifo : single-clock FIFO with count-based full/empty and head output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vc_plane_fifo
  import vc_plane_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observable while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_plane_rx_buffer.sv
// ---------------------------------------------------------------------------
// vc_plane_rx_buffer : per-VC receive buffering, credit return and optional
// plane-sequence check (enabled by VC_PLANE_SYNC_CHECK_EN). Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vc_plane_rx_buffer
  import vc_plane_pkg::*;
#(
  parameter int VC         = VC_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [plane_idx_width(VC)-1:0] VCPlaneSelector,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [VC*DATA_WIDTH-1:0]      dout,
  output logic [VC-1:0]                 valid_out,
  input  logic [VC-1:0]                 ready_in,
  output logic [VC-1:0]                 credit_out,
  output logic                          sync_error
);

  localparam int PW = plane_idx_width(VC);
  localparam int SW = clog2(VC);

  logic          w_sel_in_range;
  logic [SW-1:0] w_sel_idx;
  logic          w_accept;
  logic [VC-1:0] w_push;
  logic [VC-1:0] w_pop;
  logic [VC-1:0] w_full;
  logic [VC-1:0] w_empty;
  logic [VC-1:0] credit_q, credit_d;

  assign w_sel_in_range = (VCPlaneSelector < PW'(VC));
  assign w_sel_idx      = VCPlaneSelector[SW-1:0];
  assign ready_out      = w_sel_in_range && !w_full[w_sel_idx];
  assign w_accept       = valid_in && ready_out;
  assign valid_out      = ~w_empty;
  assign w_pop          = valid_out & ready_in;

  for (genvar g = 0; g < VC; g++) begin : g_fifo
    assign w_push[g] = w_accept && (w_sel_idx == SW'(g));

    vc_plane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push[g]),
      .data_i  (din),
      .pop_i   (w_pop[g]),
      .full_o  (w_full[g]),
      .empty_o (w_empty[g]),
      .head_o  (dout[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign credit_d   = w_pop;
  assign credit_out = credit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

`ifdef VC_PLANE_SYNC_CHECK_EN
  // Mirror of the sender's round-robin plane counter; never resynchronised.
  logic [SW-1:0] mirror_q, mirror_d;
  logic          sync_error_q, sync_error_d;

  always_comb begin
    mirror_d     = (mirror_q == SW'(VC - 1)) ? '0 : mirror_q + SW'(1);
    sync_error_d = sync_error_q | (VCPlaneSelector != PW'(mirror_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mirror_q     <= '0;
      sync_error_q <= 1'b0;
    end else begin
      mirror_q     <= mirror_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign sync_error = sync_error_q;
`else
  assign sync_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_plane_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_plane_rx_buffer : directed and randomised checks for vc_plane_rx_buffer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vc_plane_rx_buffer;

  localparam int VC    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

`ifdef VC_PLANE_SYNC_CHECK_EN
  localparam logic SYNC_EN = 1'b1;
`else
  localparam logic SYNC_EN = 1'b0;
`endif

  typedef logic [DW-1:0] flit_q_t[$];

  logic           clk;
  logic           rst;
  logic [VC:0]    sel;
  logic [DW-1:0]  din;
  logic           valid_in;
  logic           ready_out;
  logic [VC*DW-1:0] dout;
  logic [VC-1:0]  valid_out;
  logic [VC-1:0]  ready_in;
  logic [VC-1:0]  credit_out;
  logic           sync_error;

  int n_tests;
  int n_fail;

  vc_plane_rx_buffer #(
    .VC         (VC),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .VCPlaneSelector (sel),
    .din             (din),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .dout            (dout),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .credit_out      (credit_out),
    .sync_error      (sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] head(input int i);
    return dout[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = '0;
    sel      = '0;
    din      = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0000", valid_out); end
    n_tests++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL reset_credit_out: got %b expected 0000", credit_out); end
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL reset_sync_error: got %b expected 0", sync_error); end
    n_tests++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_out: got %b expected 1", ready_out); end
  endtask

  task automatic test_fill_order();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      sel      = 5'(c % VC);
      din      = 32'h100 + 32'(c);
      valid_in = 1'b1;
      #1;
      n_tests++;
      if (ready_out !== (c < 16)) begin
        n_fail++; $display("FAIL fill_ready_out cycle %0d: got %b expected %b", c, ready_out, (c < 16));
      end
      tick();
    end
    valid_in = 1'b0;
    n_tests++; if (valid_out !== 4'b1111) begin n_fail++; $display("FAIL fill_valid_out: got %b expected 1111", valid_out); end
    for (int i = 0; i < VC; i++) begin
      n_tests++;
      if (head(i) !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL fill_head vc%0d: got %h expected %h", i, head(i), 32'h100 + 32'(i));
      end
    end
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL fill_sync_error: got %b expected 0", sync_error); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      sel = 5'd2; din = 32'hA0 + 32'(k); valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    n_tests++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL drain_credit_idle: got %b expected 0000", credit_out); end
    for (int k = 0; k < DEPTH; k++) begin
      ready_in = 4'b0100;
      n_tests++;
      if (head(2) !== 32'hA0 + 32'(k)) begin
        n_fail++; $display("FAIL drain_head pop%0d: got %h expected %h", k, head(2), 32'hA0 + 32'(k));
      end
      n_tests++; if (valid_out[2] !== 1'b1) begin n_fail++; $display("FAIL drain_valid pop%0d: got %b expected 1", k, valid_out[2]); end
      tick();
      n_tests++;
      if (credit_out !== 4'b0100) begin
        n_fail++; $display("FAIL drain_credit pop%0d: got %b expected 0100", k, credit_out);
      end
    end
    ready_in = '0;
    n_tests++; if (valid_out[2] !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", valid_out[2]); end
    tick();
    n_tests++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL drain_credit_end: got %b expected 0000", credit_out); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_h [4];
    exp_h[0] = 32'hB1; exp_h[1] = 32'hB2; exp_h[2] = 32'hB3; exp_h[3] = 32'hBE;
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      sel = 5'd1; din = 32'hB0 + 32'(k); valid_in = 1'b1;
      tick();
    end
    din = 32'hBF; ready_in = 4'b0010;
    #1;
    n_tests++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL fullpp_refuse: got %b expected 0", ready_out); end
    tick();
    valid_in = 1'b0; ready_in = '0;
    n_tests++; if (credit_out !== 4'b0010) begin n_fail++; $display("FAIL fullpp_credit: got %b expected 0010", credit_out); end
    n_tests++; if (head(1) !== 32'hB1) begin n_fail++; $display("FAIL fullpp_head: got %h expected %h", head(1), 32'hB1); end
    #1;
    n_tests++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL fullpp_ready_after: got %b expected 1", ready_out); end
    valid_in = 1'b1; din = 32'hBE;
    tick();
    valid_in = 1'b0;
    #1;
    n_tests++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL fullpp_refull: got %b expected 0", ready_out); end
    for (int k = 0; k < DEPTH; k++) begin
      ready_in = 4'b0010;
      n_tests++;
      if (head(1) !== exp_h[k]) begin
        n_fail++; $display("FAIL fullpp_order pop%0d: got %h expected %h", k, head(1), exp_h[k]);
      end
      tick();
    end
    ready_in = '0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL oor_sync_init: got %b expected 0", sync_error); end
    sel = 5'd5; valid_in = 1'b1; din = 32'hDEAD;
    #1;
    n_tests++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL oor_ready: got %b expected 0", ready_out); end
    tick();
    sel = 5'd0; valid_in = 1'b0;
    n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL oor_valid_out: got %b expected 0000", valid_out); end
    n_tests++; if (sync_error !== SYNC_EN) begin n_fail++; $display("FAIL oor_sync: got %b expected %b", sync_error, SYNC_EN); end
    tick();
    tick();
    n_tests++; if (sync_error !== SYNC_EN) begin n_fail++; $display("FAIL oor_sync_sticky: got %b expected %b", sync_error, SYNC_EN); end
  endtask

  task automatic test_sync_and_reset();
    do_reset();
    sel = 5'd0; din = 32'hC0; valid_in = 1'b1;
    tick();
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL seq_sync_0: got %b expected 0", sync_error); end
    sel = 5'd1; din = 32'hC1;
    tick();
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL seq_sync_1: got %b expected 0", sync_error); end
    sel = 5'd3; din = 32'hC3;
    tick();
    n_tests++; if (sync_error !== SYNC_EN) begin n_fail++; $display("FAIL seq_sync_3: got %b expected %b", sync_error, SYNC_EN); end
    sel = 5'd2; valid_in = 1'b0; ready_in = 4'b0001;
    tick();
    ready_in = '0;
    n_tests++; if (credit_out !== 4'b0001) begin n_fail++; $display("FAIL seq_credit_pending: got %b expected 0001", credit_out); end
    n_tests++; if (valid_out !== 4'b1010) begin n_fail++; $display("FAIL seq_valid_before_rst: got %b expected 1010", valid_out); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (sync_error !== 1'b0) begin n_fail++; $display("FAIL async_rst_sync: got %b expected 0", sync_error); end
    n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0000", valid_out); end
    n_tests++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL async_rst_credit: got %b expected 0000", credit_out); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    flit_q_t       q [VC];
    logic          exp_ready;
    logic [VC-1:0] exp_credit;
    int            accepted;
    int            credits;
    int            residual;
    accepted = 0;
    credits  = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      sel      = 5'($urandom_range(0, VC));
      valid_in = 1'($urandom_range(0, 1));
      din      = $urandom;
      ready_in = 4'($urandom);
      #1;
      exp_ready = (sel < 5'(VC)) && (q[sel[1:0]].size() < DEPTH);
      n_tests++;
      if (ready_out !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready cycle %0d: got %b expected %b", c, ready_out, exp_ready);
      end
      for (int i = 0; i < VC; i++) begin
        n_tests++;
        if (valid_out[i] !== (q[i].size() != 0)) begin
          n_fail++; $display("FAIL rnd_valid cycle %0d vc%0d: got %b expected %b", c, i, valid_out[i], (q[i].size() != 0));
        end else if (q[i].size() != 0 && head(i) !== q[i][0]) begin
          n_fail++; $display("FAIL rnd_head cycle %0d vc%0d: got %h expected %h", c, i, head(i), q[i][0]);
        end
      end
      exp_credit = '0;
      for (int i = 0; i < VC; i++) begin
        if (q[i].size() != 0 && ready_in[i]) begin
          void'(q[i].pop_front());
          exp_credit[i] = 1'b1;
        end
      end
      if (exp_ready && valid_in) begin
        q[sel[1:0]].push_back(din);
        accepted++;
      end
      tick();
      n_tests++;
      if (credit_out !== exp_credit) begin
        n_fail++; $display("FAIL rnd_credit cycle %0d: got %b expected %b", c, credit_out, exp_credit);
      end
      credits += $countones(credit_out);
    end
    ready_in = '0; valid_in = 1'b0;
    residual = 0;
    for (int i = 0; i < VC; i++) residual += q[i].size();
    n_tests++;
    if (credits !== accepted - residual) begin
      n_fail++; $display("FAIL rnd_credit_total: got %0d expected %0d", credits, accepted - residual);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    sel      = '0;
    din      = '0;
    valid_in = 1'b0;
    ready_in = '0;
    test_reset();
    test_fill_order();
    test_drain();
    test_full_push_pop();
    test_out_of_range();
    test_sync_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_plane_rx_buffer.md
Name: vc_plane_rx_buffer

Overview:
- Receiving end of the time-multiplexed VC-plane link.
- The upstream sender drives one flit per cycle, tagged with its current VC plane index, which is the round-robin selector value 0..VC-1 wrapping every VC cycles.
- This block demultiplexes incoming flits into per-VC FIFOs and presents per-VC head flits to the downstream consumer.
- It returns per-VC credit pulses upstream and optionally checks that the sender's plane sequence stays in lockstep with a local mirror counter.

Parameters:
- VC, 4: number of virtual channels / planes; must be ≥2.
- DATA_WIDTH, 32: flit width in bits.
- FIFO_DEPTH, 4: entries per VC FIFO; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- VCPlaneSelector  in  VC+1  sender's active plane index this cycle; same width as the controller selector buses
- din  in  DATA_WIDTH  incoming flit
- valid_in  in  1  din valid this cycle
- ready_out  out  1  FIFO of the selected plane can accept din
- dout  out  VC*DATA_WIDTH  per-VC head flit; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- valid_out  out  VC  bit i: FIFO i non-empty
- ready_in  in  VC  bit i: consumer pops VC i
- credit_out  out  VC  bit i: registered one-cycle pulse per flit popped from VC i
- sync_error  out  1  sticky plane-sequence error (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - All FIFOs empty; pointers and counts 0.
  - valid_out=0, credit_out=0, sync_error=0, mirror counter=0.
  - dout content is don't-care while valid_out=0.
- ready_out is combinational:
  - 1 iff VCPlaneSelector < VC and count[sel] < FIFO_DEPTH.
  - Upper selector bits must be zero for a valid index.
- Push: valid_in && ready_out at a rising edge writes din into FIFO[sel].
  - The flit is visible on dout/valid_out of that VC the next cycle, i.e. 1-cycle latency.
- Pop: valid_out[i] && ready_in[i] at an edge advances the read pointer of FIFO i.
  - ready_in[i] while empty is ignored: no pointer move, no credit.
- credit_out[i] asserts for exactly one cycle, the cycle after each pop of VC i.
- Same-VC push and pop in one cycle:
  - Both happen; count unchanged.
  - When full, the push is still refused; there is no same-cycle bypass.
  - When empty, the pop is not possible, since valid_out=0 that cycle.
- Pops on multiple VCs in one cycle are independent; several credit_out bits may pulse together.
- Out-of-range selector (≥VC):
  - ready_out=0 and no write, regardless of valid_in.
  - FIFO state is otherwise unaffected.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished.
- Mid-operation reset discards all buffered flits and any pending credit pulse.

Optional Feature:
- Macro: VC_PLANE_SYNC_CHECK_EN
- Defined:
  - A mirror counter starts at 0 after reset and increments each cycle, wrapping from VC-1 to 0, exactly as the sender's plane controller does.
  - Any cycle where VCPlaneSelector ≠ mirror sets sync_error on the next edge.
  - sync_error is sticky until rst.
  - The mirror keeps counting; it does not resynchronise.
- Not defined: no mirror counter; sync_error tied 0. Out-of-range blocking still applies.

Decomposition:
- Shared package (vc_plane_pkg):
  - default VC, DATA_WIDTH, FIFO_DEPTH constants;
  - a clog2 helper;
  - the plane-index width constant (VC+1), shared with the plane controller.
- One sub-module, vc_plane_fifo:
  - single synchronous FIFO with push, pop, full, empty, head data;
  - instantiated VC times by generate.
- Top level holds the demux, ready_out mux, credit registers and the optional sync checker.

Test Plan:
1. Reset, then drive selector 0,1,2,3,0… with valid_in=1, din=0x100+cycle, all ready_in=0 → each FIFO fills in order.
   - ready_out drops on the cycle selector first hits an already-full VC, i.e. the 17th cycle at FIFO_DEPTH=4.
   - Stored heads are 0x100..0x103.
2. Fill VC2 with 4 flits. Hold ready_in[2]=1 for 4 cycles → dout slice 2 shows the flits in FIFO order; credit_out[2] pulses 4 times, each one cycle after its pop; valid_out[2]=0 afterwards.
3. VC1 full. Same cycle: push to VC1 and ready_in[1]=1 → push refused (ready_out=0), one pop occurs, count goes 4→3; next cycle ready_out=1 for selector 1.
4. Selector=5, valid_in=1 → ready_out=0; no valid_out bit changes.
   - With the macro: sync_error=1 next cycle and stays 1.
   - Without the macro: sync_error stays 0.
5. With the macro, selector sequence 0,1,3 → sync_error rises the cycle after 3 is driven. Assert rst mid-stream → sync_error=0, all valid_out=0, credit_out=0 immediately, without waiting for a clock edge.
6. Random push/pop on all VCs for 10k cycles → the scoreboard checks per-VC ordering; credits popped equal flits accepted minus residual occupancy.
